// File: rtl/kovacs_protocol_sequencer.sv
// kovacs_protocol_sequencer
//   Programmable N-phase protocol sequencer. It steps through a latched phase
//   table, where each phase has a hold length, a source select and an indicator
//   level. It drives a width-reduced DAC word and a phase indicator.
//   Build macro KOVACS_SEQ_ROUND_EN: when defined, the width reduction is
//   round-half-up with positive saturation. When undefined (the default), the
//   width reduction is plain truncation.
module kovacs_protocol_sequencer #(
    parameter int DATA_W   = 16,
    parameter int OUT_W    = 14,
    parameter int N_SRC    = 3,
    parameter int N_PHASES = 4,
    parameter int CNT_W    = 32,
    localparam int SW      = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    localparam int PHW     = $clog2(N_PHASES),
    localparam int NPW     = $clog2(N_PHASES) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_SRC*DATA_W-1:0]   data_i,
    input  logic [N_PHASES*CNT_W-1:0] phase_len_i,
    input  logic [N_PHASES*SW-1:0]    phase_src_i,
    input  logic [N_PHASES*OUT_W-1:0] phase_ind_i,
    input  logic [NPW-1:0]            n_phases_i,
    input  logic [CNT_W-1:0]          n_cycles_i,
    input  logic                      start_i,
    input  logic                      stop_i,
    output logic [OUT_W-1:0]          data_o,
    output logic [OUT_W-1:0]          indicator_o,
    output logic [PHW-1:0]            phase_o,
    output logic                      busy_o,
    output logic                      cycle_done_o,
    output logic                      done_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam int SH = DATA_W - OUT_W;

`ifdef KOVACS_SEQ_ROUND_EN
    localparam int              RSH = (SH > 0) ? SH - 1 : 0;
    localparam logic [DATA_W:0] RND = (SH > 0) ? ((DATA_W+1)'(1) << RSH) : '0;
`endif

    // Reduce a signed sample to OUT_W bits, keeping the sign.
    function automatic logic [OUT_W-1:0] f_reduce(input logic [DATA_W-1:0] s);
`ifdef KOVACS_SEQ_ROUND_EN
        logic [DATA_W:0] sum;
        // The rounding constant is positive, so only positive overflow is possible.
        sum = {s[DATA_W-1], s} + RND;
        if (!sum[DATA_W] && sum[DATA_W-1])
            return {1'b0, {(OUT_W-1){1'b1}}};
        return OUT_W'(sum >> SH);
`else
        return OUT_W'($signed(s) >>> SH);
`endif
    endfunction

    // Pick one source sample. An out-of-range index falls back to source 0.
    function automatic logic [DATA_W-1:0] f_pick(input logic [N_SRC*DATA_W-1:0] d,
                                                 input logic [SW-1:0]           idx);
        logic [DATA_W-1:0] v;
        v = d[DATA_W-1:0];
        for (int unsigned s = 1; s < N_SRC; s++)
            if (idx == SW'(s))
                v = d[s*DATA_W +: DATA_W];
        return v;
    endfunction

    logic [0:0]                r_state;
    logic [PHW-1:0]            r_phase;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          r_rep;
    logic [N_PHASES*CNT_W-1:0] r_len;
    logic [N_PHASES*SW-1:0]    r_src;
    logic [N_PHASES*OUT_W-1:0] r_ind;
    logic [NPW-1:0]            r_np;
    logic [CNT_W-1:0]          r_ncyc;
    logic [OUT_W-1:0]          r_data;
    logic [OUT_W-1:0]          r_ind_o;
    logic                      r_cycle_done;
    logic                      r_done;

    logic [NPW-1:0]            w_np_clamp;
    logic [CNT_W-1:0]          w_len_cur;
    logic [SW-1:0]             w_src_cur;
    logic [OUT_W-1:0]          w_ind_cur;
    logic                      w_phase_end;
    logic                      w_last;
    logic [CNT_W-1:0]          w_rep_next;

    // Clamp the requested phase count into [2, N_PHASES].
    always_comb begin
        w_np_clamp = n_phases_i;
        if (n_phases_i < NPW'(2))
            w_np_clamp = NPW'(2);
        else if (n_phases_i > NPW'(N_PHASES))
            w_np_clamp = NPW'(N_PHASES);
    end

    // Look up the latched table entry for the current phase.
    always_comb begin
        w_len_cur = r_len[CNT_W-1:0];
        w_src_cur = r_src[SW-1:0];
        w_ind_cur = r_ind[OUT_W-1:0];
        for (int unsigned p = 1; p < N_PHASES; p++) begin
            if (r_phase == PHW'(p)) begin
                w_len_cur = r_len[p*CNT_W +: CNT_W];
                w_src_cur = r_src[p*SW +: SW];
                w_ind_cur = r_ind[p*OUT_W +: OUT_W];
            end
        end
    end

    // Compare before incrementing, so a length of all ones never overflows.
    assign w_phase_end = (r_cnt == w_len_cur);
    assign w_last      = ({1'b0, r_phase} == (r_np - NPW'(1)));
    assign w_rep_next  = r_rep + CNT_W'(1);

    // Sequencer FSM: latch configuration on start, then step phases and repeats.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_phase      <= '0;
            r_cnt        <= '0;
            r_rep        <= '0;
            r_len        <= '0;
            r_src        <= '0;
            r_ind        <= '0;
            r_np         <= '0;
            r_ncyc       <= '0;
            r_cycle_done <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_cycle_done <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i && !stop_i) begin
                        r_len   <= phase_len_i;
                        r_src   <= phase_src_i;
                        r_ind   <= phase_ind_i;
                        r_np    <= w_np_clamp;
                        r_ncyc  <= n_cycles_i;
                        r_cnt   <= '0;
                        r_rep   <= '0;
                        r_phase <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_phase_end) begin
                        r_cnt <= '0;
                        if (w_last) begin
                            r_cycle_done <= 1'b1;
                            r_rep        <= w_rep_next;
                            r_phase      <= '0;
                            if (!stop_i && (r_ncyc != '0) && (w_rep_next == r_ncyc)) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_phase <= r_phase + PHW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    // Stop overrides the phase step but still lets a wrap report cycle_done.
                    if (stop_i) begin
                        r_state <= S_IDLE;
                        r_phase <= '0;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output stage: register the DAC word and indicator from the current phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data  <= '0;
            r_ind_o <= '0;
        end else if (r_state == S_RUN) begin
            r_data  <= f_reduce(f_pick(data_i, w_src_cur));
            r_ind_o <= w_ind_cur;
        end else begin
            r_data  <= f_reduce(f_pick(data_i, phase_src_i[SW-1:0]));
            r_ind_o <= '0;
        end
    end

    assign data_o       = r_data;
    assign indicator_o  = r_ind_o;
    assign phase_o      = r_phase;
    assign busy_o       = (r_state == S_RUN);
    assign cycle_done_o = r_cycle_done;
    assign done_o       = r_done;

endmodule

// File: tb/tb_kovacs_protocol_sequencer.sv
// Testbench for kovacs_protocol_sequencer: directed scenarios plus randomized
// traffic, checked every cycle against a time-based reference model.
module tb_kovacs_protocol_sequencer;

    localparam int DATA_W   = 16;
    localparam int OUT_W    = 14;
    localparam int N_SRC    = 3;
    localparam int N_PHASES = 4;
    localparam int CNT_W    = 32;
    localparam int SW       = 2;
    localparam int PHW      = 2;
    localparam int NPW      = 3;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic [N_SRC*DATA_W-1:0]   data_i;
    logic [N_PHASES*CNT_W-1:0] phase_len_i;
    logic [N_PHASES*SW-1:0]    phase_src_i;
    logic [N_PHASES*OUT_W-1:0] phase_ind_i;
    logic [NPW-1:0]            n_phases_i;
    logic [CNT_W-1:0]          n_cycles_i;
    logic                      start_i;
    logic                      stop_i;
    logic [OUT_W-1:0]          data_o;
    logic [OUT_W-1:0]          indicator_o;
    logic [PHW-1:0]            phase_o;
    logic                      busy_o;
    logic                      cycle_done_o;
    logic                      done_o;

    kovacs_protocol_sequencer #(
        .DATA_W   (DATA_W),
        .OUT_W    (OUT_W),
        .N_SRC    (N_SRC),
        .N_PHASES (N_PHASES),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .phase_len_i  (phase_len_i),
        .phase_src_i  (phase_src_i),
        .phase_ind_i  (phase_ind_i),
        .n_phases_i   (n_phases_i),
        .n_cycles_i   (n_cycles_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .data_o       (data_o),
        .indicator_o  (indicator_o),
        .phase_o      (phase_o),
        .busy_o       (busy_o),
        .cycle_done_o (cycle_done_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: a run is a position t (cycles since entering RUN);
    // phase, wraps and completion follow from the period arithmetic.
    bit     m_run;
    longint m_t;
    longint m_len [N_PHASES];
    int     m_src [N_PHASES];
    int     m_ind [N_PHASES];
    int     m_np;
    longint m_ncyc;
    int     e_data, e_ind, e_phase, e_busy, e_cd, e_done;

    function automatic longint period();
        longint p = 0;
        for (int k = 0; k < m_np; k++) p += m_len[k] + 1;
        return p;
    endfunction

    function automatic int phase_at(input longint t);
        longint off;
        off = t % period();
        for (int k = 0; k < m_np; k++) begin
            if (off <= m_len[k]) return k;
            off -= m_len[k] + 1;
        end
        return 0;
    endfunction

    function automatic logic [DATA_W-1:0] src_val(input int idx);
        int i;
        i = (idx >= N_SRC) ? 0 : idx;
        return data_i[i*DATA_W +: DATA_W];
    endfunction

    function automatic int reduce_ref(input logic [DATA_W-1:0] w);
        int v, r, sh;
        sh = DATA_W - OUT_W;
        v  = int'($signed(w));
`ifdef KOVACS_SEQ_ROUND_EN
        r = (sh > 0) ? ((v + (1 << (sh - 1))) >>> sh) : v;
        if (r > (1 << (OUT_W - 1)) - 1) r = (1 << (OUT_W - 1)) - 1;
`else
        r = v >>> sh;
`endif
        return r & ((1 << OUT_W) - 1);
    endfunction

    task automatic latch_config();
        int n;
        for (int k = 0; k < N_PHASES; k++) begin
            m_len[k] = longint'(phase_len_i[k*CNT_W +: CNT_W]);
            m_src[k] = int'(phase_src_i[k*SW +: SW]);
            m_ind[k] = int'(phase_ind_i[k*OUT_W +: OUT_W]);
        end
        n = int'(n_phases_i);
        m_np   = (n < 2) ? 2 : ((n > N_PHASES) ? N_PHASES : n);
        m_ncyc = longint'(n_cycles_i);
    endtask

    task automatic model_reset();
        m_run = 0; m_t = 0;
        e_data = 0; e_ind = 0; e_phase = 0; e_busy = 0; e_cd = 0; e_done = 0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        int ph;
        longint p;
        bit wrap;
        if (m_run) begin
            ph     = phase_at(m_t);
            e_data = reduce_ref(src_val(m_src[ph]));
            e_ind  = m_ind[ph];
        end else begin
            e_data = reduce_ref(src_val(int'(phase_src_i[SW-1:0])));
            e_ind  = 0;
        end
        e_cd = 0; e_done = 0;
        if (!m_run) begin
            if (start_i && !stop_i) begin
                latch_config();
                m_run = 1; m_t = 0;
            end
        end else begin
            p    = period();
            wrap = ((m_t + 1) % p) == 0;
            e_cd = int'(wrap);
            if (stop_i) m_run = 0;
            else if (wrap && m_ncyc != 0 && (m_t + 1) / p == m_ncyc) begin
                e_done = 1; m_run = 0;
            end else m_t++;
        end
        e_busy  = int'(m_run);
        e_phase = m_run ? phase_at(m_t) : 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".data"},  64'(data_o),       64'(e_data));
        check_eq({tag, ".ind"},   64'(indicator_o),  64'(e_ind));
        check_eq({tag, ".phase"}, 64'(phase_o),      64'(e_phase));
        check_eq({tag, ".busy"},  64'(busy_o),       64'(e_busy));
        check_eq({tag, ".cdone"}, 64'(cycle_done_o), 64'(e_cd));
        check_eq({tag, ".done"},  64'(done_o),       64'(e_done));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs("cyc");
    endtask

    task automatic rand_data();
        for (int s = 0; s < N_SRC; s++) data_i[s*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    task automatic rand_cfg();
        for (int k = 0; k < N_PHASES; k++) begin
            phase_len_i[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 4));
            phase_src_i[k*SW +: SW]       = SW'($urandom_range(0, 3));
            phase_ind_i[k*OUT_W +: OUT_W] = OUT_W'($urandom);
        end
        n_phases_i = NPW'($urandom_range(0, 7));
        n_cycles_i = CNT_W'($urandom_range(0, 3));
    endtask

    task automatic go_idle();
        start_i = 0; stop_i = 1; step(); stop_i = 0; step();
    endtask

    logic [15:0] wvec [3];
    logic [13:0] wexp [3];

    initial begin
        int k1, kd, ncd, maxph;
        rst_i = 1; start_i = 0; stop_i = 0;
        data_i = '0; phase_len_i = '0; phase_src_i = '0; phase_ind_i = '0;
        n_phases_i = '0; n_cycles_i = '0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 0;
        check_outputs("reset");

        // Width reduction in IDLE through phase-0 source 0.
        wvec[0] = 16'h7FFF; wvec[1] = 16'h0002; wvec[2] = 16'h8001;
`ifdef KOVACS_SEQ_ROUND_EN
        wexp[0] = 14'h1FFF; wexp[1] = 14'h0001; wexp[2] = 14'h2000;
`else
        wexp[0] = 14'h1FFF; wexp[1] = 14'h0000; wexp[2] = 14'h2000;
`endif
        for (int i = 0; i < 3; i++) begin
            data_i[DATA_W-1:0] = wvec[i];
            step();
            check_eq("width", 64'(data_o), 64'(wexp[i]));
        end

        // Basic three-phase run, two repetitions.
        phase_len_i = '0;
        phase_len_i[0*CNT_W +: CNT_W] = 4;
        phase_len_i[1*CNT_W +: CNT_W] = 9;
        phase_len_i[2*CNT_W +: CNT_W] = 2;
        phase_src_i = 8'b00_01_10_00;
        phase_ind_i = '0;
        phase_ind_i[1*OUT_W +: OUT_W] = 14'd8191;
        phase_ind_i[2*OUT_W +: OUT_W] = 14'd4096;
        n_phases_i = 3; n_cycles_i = 2;
        start_i = 1; rand_data(); step(); start_i = 0;
        k1 = -1; kd = -1; ncd = 0;
        for (int k = 0; k < 40; k++) begin
            if (cycle_done_o) begin ncd++; if (k1 < 0) k1 = k; end
            if (done_o) kd = k;
            if (k == 5)  begin check_eq("basic.ph1", 64'(phase_o), 1); check_eq("basic.ind_lag", 64'(indicator_o), 0); end
            if (k == 6)  check_eq("basic.ind1", 64'(indicator_o), 8191);
            if (k == 15) check_eq("basic.ph2", 64'(phase_o), 2);
            if (k == 16) check_eq("basic.ind2", 64'(indicator_o), 4096);
            if (k == 35) check_eq("basic.busy_hi", 64'(busy_o), 1);
            if (k == 36) check_eq("basic.busy_lo", 64'(busy_o), 0);
            rand_data(); step();
        end
        check_eq("basic.ncd", 64'(ncd), 2);
        check_eq("basic.cd1", 64'(k1), 18);
        check_eq("basic.done", 64'(kd), 36);

        // One-cycle phases, infinite repeat, stop on a wrap cycle.
        phase_len_i = '0; n_phases_i = 2; n_cycles_i = 0;
        start_i = 1; rand_data(); step(); start_i = 0;
        for (int k = 0; k < 22; k++) begin
            check_eq("bnd.phase", 64'(phase_o), 64'(k % 2));
            check_eq("bnd.cd", 64'(cycle_done_o), 64'((k >= 2) && (k % 2 == 0)));
            if (k == 21) stop_i = 1;
            rand_data(); step();
        end
        stop_i = 0;
        check_eq("stopwrap.cd", 64'(cycle_done_o), 1);
        check_eq("stopwrap.done", 64'(done_o), 0);
        check_eq("stopwrap.busy", 64'(busy_o), 0);
        repeat (3) begin rand_data(); step(); end

        // Configuration freeze with start held high.
        phase_len_i = '0;
        phase_len_i[0*CNT_W +: CNT_W] = 2;
        phase_len_i[1*CNT_W +: CNT_W] = 3;
        phase_src_i = 8'b00_00_10_01;
        n_phases_i = 2; n_cycles_i = 1;
        start_i = 1; rand_data(); step();
        for (int k = 0; k < 9; k++) begin
            if (k == 1) begin
                for (int p = 0; p < N_PHASES; p++) phase_len_i[p*CNT_W +: CNT_W] = 7;
                phase_src_i = '0;
            end
            if (k < 7) check_eq("freeze.busy", 64'(busy_o), 1);
            if (k == 7) begin check_eq("freeze.done", 64'(done_o), 1); check_eq("freeze.idle", 64'(busy_o), 0); end
            if (k == 8) check_eq("freeze.restart", 64'(busy_o), 1);
            rand_data(); step();
        end
        go_idle();

        // Asynchronous reset in the middle of phase 1.
        phase_len_i = '0;
        phase_len_i[0*CNT_W +: CNT_W] = 3;
        phase_len_i[1*CNT_W +: CNT_W] = 6;
        rand_cfg();
        phase_len_i[0*CNT_W +: CNT_W] = 3;
        phase_len_i[1*CNT_W +: CNT_W] = 6;
        n_phases_i = 2; n_cycles_i = 0;
        start_i = 1; rand_data(); step(); start_i = 0;
        for (int i = 0; i < 20 && phase_o != 1; i++) begin rand_data(); step(); end
        check_eq("rst.reach_ph1", 64'(phase_o), 1);
        rand_data(); step(); rand_data(); step();
        #2 rst_i = 1;
        #1;
        check_eq("arst.data",  64'(data_o), 0);
        check_eq("arst.ind",   64'(indicator_o), 0);
        check_eq("arst.phase", 64'(phase_o), 0);
        check_eq("arst.busy",  64'(busy_o), 0);
        check_eq("arst.cd",    64'(cycle_done_o), 0);
        check_eq("arst.done",  64'(done_o), 0);
        @(negedge clk_i);
        rst_i = 0;
        model_reset();
        check_outputs("post_rst");

        // Clamping: phase count above and below range, out-of-range source.
        data_i = {16'h5555, 16'h2AAA, 16'h1234};
        for (int p = 0; p < N_PHASES; p++) phase_len_i[p*CNT_W +: CNT_W] = 1;
        phase_src_i = 8'b00_00_00_11;
        n_phases_i = 7; n_cycles_i = 1;
        start_i = 1; step(); start_i = 0;
        maxph = 0;
        for (int k = 0; k < 12; k++) begin
            if (int'(phase_o) > maxph) maxph = int'(phase_o);
            if (k == 1) check_eq("clamp.src3", 64'(data_o), 64'(14'h048D));
            step();
        end
        check_eq("clamp.np7", 64'(maxph), 3);
        n_phases_i = 0;
        start_i = 1; step(); start_i = 0;
        maxph = 0;
        for (int k = 0; k < 8; k++) begin
            if (int'(phase_o) > maxph) maxph = int'(phase_o);
            step();
        end
        check_eq("clamp.np0", 64'(maxph), 1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) rand_cfg();
            start_i = ($urandom_range(0, 3) == 0);
            stop_i  = ($urandom_range(0, 39) == 0);
            rand_data();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/kovacs_protocol_sequencer.md
Name: kovacs_protocol_sequencer

Overview:
- Parametrised N-phase protocol sequencer. Generalises the fixed three-phase, two-interval scheme to a programmable phase table.
- Each phase has:
  - a hold duration;
  - a source-select into N_SRC input streams;
  - an indicator level.
- Adds start/stop control, a finite or infinite repeat count, and status outputs.
- Sits between the filter/rescaler outputs and the DAC channel. It drives the DAC word and a phase indicator for the scope/logging channel.

Parameters:
- DATA_W, 16, width of each input source sample (signed two's complement).
- OUT_W, 14, width of data_o and indicator_o; must be <= DATA_W.
- N_SRC, 3, number of selectable input sources (>= 2).
- N_PHASES, 4, maximum phases in the table (>= 2).
- CNT_W, 32, width of phase-length and repeat counters.

Ports:
- clk_i, in, 1, system clock.
- rst_i, in, 1, asynchronous active-high reset.
- data_i, in, N_SRC*DATA_W, source samples, source s at bits [s*DATA_W +: DATA_W].
- phase_len_i, in, N_PHASES*CNT_W, per-phase length L; phase lasts L+1 cycles.
- phase_src_i, in, N_PHASES*SW, per-phase source index; SW = max(1, clog2(N_SRC)).
- phase_ind_i, in, N_PHASES*OUT_W, per-phase indicator level.
- n_phases_i, in, clog2(N_PHASES)+1, active phase count.
- n_cycles_i, in, CNT_W, protocol repetitions; 0 = run until stop.
- start_i, in, 1, start request (level; rising edge not required).
- stop_i, in, 1, abort request.
- data_o, out, OUT_W, selected source, reduced to OUT_W.
- indicator_o, out, OUT_W, current phase indicator.
- phase_o, out, clog2(N_PHASES), current phase index.
- busy_o, out, 1, high in RUN.
- cycle_done_o, out, 1, one-cycle pulse at each wrap of the last phase back to phase 0.
- done_o, out, 1, one-cycle pulse when the final repetition completes.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters 0, latched configuration 0. Takes effect immediately, including mid-run.
- FSM states: IDLE, RUN.
- IDLE:
  - data_o tracks the phase-0 source of the live inputs; indicator_o = 0; phase_o = 0.
  - start_i=1 and stop_i=0: latch all configuration inputs, clear counters, enter RUN at phase 0 on the next edge.
- Configuration handling:
  - Configuration is frozen for the whole run; input changes during RUN are ignored.
  - Effective phase count NP = clamp(n_phases_i, 2, N_PHASES).
  - A latched source index >= N_SRC selects source 0.
- RUN timing:
  - Phase counter counts 0..L_k. At count == L_k it clears, and the phase advances to k+1, or to 0 if k == NP-1.
  - L = 0 gives a one-cycle phase.
  - L = 2^CNT_W-1 is legal; no overflow, because the compare precedes the increment.
- RUN repeats:
  - On the last-phase wrap: cycle_done_o pulses and the repeat counter increments.
  - If n_cycles != 0 and the repeat counter reaches n_cycles: done_o pulses with cycle_done_o, and the FSM returns to IDLE instead of phase 0.
- stop_i:
  - Priority over everything except reset.
  - In RUN: go to IDLE next edge, no done_o.
  - Simultaneous with a wrap: cycle_done_o still pulses, done_o does not.
- start_i in RUN is ignored (no restart).
- Output pipeline:
  - data_o and indicator_o are registered from the current phase, giving 1 cycle latency from the phase change.
  - phase_o and busy_o are registered state; they change on the same edge as the phase.
- Width reduction: data_o = sample[DATA_W-1 -: OUT_W] (truncation, sign preserved).

Optional Feature:
- Macro: KOVACS_SEQ_ROUND_EN.
- Defined:
  - Reduction is round-half-up: add 1 << (DATA_W-OUT_W-1), then take the top OUT_W bits.
  - Saturate to the signed OUT_W max, 2^(OUT_W-1)-1, on positive overflow.
  - When DATA_W == OUT_W, behaves as a pass-through.
- Undefined: plain truncation as above.
- Latency is unchanged either way.

Test Plan:
- Basic three-phase run. Config: N_PHASES=4; NP=3; L={4,9,2}; src={0,2,1}; ind={0,8191,4096}; n_cycles=2; start_i pulse.
  - Phases last 5/10/3 cycles; indicator follows 1 cycle after phase_o.
  - cycle_done_o pulses after cycle 18 and cycle 36; done_o with the second pulse; busy_o drops.
- Phase-length boundary. L={0,0}, NP=2, n_cycles=0.
  - phase_o toggles every cycle; cycle_done_o pulses every 2 cycles indefinitely until stop_i.
  - After stop_i: IDLE on the next edge, done_o stays 0.
- Configuration freeze. Change phase_len_i and phase_src_i mid-run.
  - No effect until the next start.
  - start_i held high in RUN causes no restart.
- Reset and stop corner cases.
  - rst_i asserted mid-phase 1: all outputs 0 asynchronously; after release, IDLE.
  - stop_i asserted on the wrap cycle: cycle_done_o=1, done_o=0.
- Clamping.
  - n_phases_i=7 with N_PHASES=4 runs 4 phases; n_phases_i=0 runs 2.
  - Source index 3 with N_SRC=3 outputs source 0.
- Width reduction. data=16'h7FFF, 16'h0002, 16'h8001.
  - Truncation: 14'h1FFF, 14'h0000, 14'h2000.
  - KOVACS_SEQ_ROUND_EN: 14'h1FFF (saturated), 14'h0001, 14'h2000.
